// File: rtl/trdb_align_stream.sv
// Packs variable-length trace packets into a gap-free byte stream and emits DATA_WIDTH-bit words.
// Define TRDB_ALIGN_LEN_HEADER_EN to prefix every packet with a one-byte payload length header.
module trdb_align_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 128
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [PKT_LEN-1:0]                pkt_bits_i,
    input  logic [$clog2(PKT_LEN):0]          pkt_len_i,
    input  logic                              pkt_valid_i,
    output logic                              pkt_ready_o,
    input  logic                              flush_i,
    output logic                              flush_done_o,
    output logic [DATA_WIDTH-1:0]             data_o,
    output logic [$clog2(DATA_WIDTH/8):0]     data_bytes_o,
    output logic                              data_valid_o,
    input  logic                              data_ready_i
);

    localparam int WB   = DATA_WIDTH / 8;
    localparam int PB   = PKT_LEN / 8;
    localparam int NB   = WB + PB + 1;
    localparam int BUFW = NB * 8;
    localparam int PVW  = (PB + 1) * 8;
    localparam int CW   = $clog2(NB + 1);
    localparam int BW   = $clog2(WB) + 1;

    typedef enum logic [1:0] {
        STREAM,
        FLUSH,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BUFW-1:0]   buffer_q, buffer_d;

    int                lenEff;
    int                payBytes;
    int                pktBytes;
    logic [PKT_LEN-1:0] payMasked;
    logic [PVW-1:0]    pktVec;
    logic [BUFW-1:0]   bufferAppend;
    logic [DATA_WIDTH-1:0] byteMask;
    logic              fullWord;
    logic              accept;
    logic              emit;

    // Clip the length, zero the bits past it and optionally prepend the header byte.
    always_comb begin
        lenEff = int'(pkt_len_i);
        if (lenEff > PKT_LEN) begin
            lenEff = PKT_LEN;
        end
        payBytes = (lenEff + 7) >> 3;
        for (int b = 0; b < PKT_LEN; b++) begin
            payMasked[b] = pkt_bits_i[b] & (b < lenEff);
        end
`ifdef TRDB_ALIGN_LEN_HEADER_EN
        pktVec   = {payMasked, 8'(payBytes)};
        pktBytes = payBytes + 1;
`else
        pktVec   = {8'h00, payMasked};
        pktBytes = payBytes;
`endif
        // Bytes at and above cnt are always zero, so OR-ing appends without gaps.
        bufferAppend = buffer_q | (BUFW'(pktVec) << {cnt_q, 3'b000});
    end

    always_comb begin
        for (int i = 0; i < WB; i++) begin
            byteMask[i*8 +: 8] = (i < int'(cnt_q)) ? 8'hFF : 8'h00;
        end
    end

    // Output word selection and state transitions.
    always_comb begin
        fullWord     = (cnt_q >= CW'(WB));
        pkt_ready_o  = (state_q == STREAM) && !fullWord;
        flush_done_o = (state_q == DONE);
        data_valid_o = 1'b0;
        data_bytes_o = '0;
        data_o       = '0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        buffer_d     = buffer_q;

        case (state_q)
            STREAM: begin
                if (fullWord) begin
                    data_valid_o = 1'b1;
                    data_bytes_o = BW'(WB);
                    data_o       = buffer_q[DATA_WIDTH-1:0];
                end
                if (flush_i) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (fullWord) begin
                    data_valid_o = 1'b1;
                    data_bytes_o = BW'(WB);
                    data_o       = buffer_q[DATA_WIDTH-1:0];
                end else if (cnt_q != '0) begin
                    data_valid_o = 1'b1;
                    data_bytes_o = BW'(cnt_q);
                    data_o       = buffer_q[DATA_WIDTH-1:0] & byteMask;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = STREAM;
            end
            default: begin
                state_d = STREAM;
            end
        endcase

        accept = pkt_valid_i && pkt_ready_o;
        emit   = data_valid_o && data_ready_i;

        if (accept) begin
            buffer_d = bufferAppend;
            cnt_d    = cnt_q + CW'(pktBytes);
        end else if (emit) begin
            if (fullWord) begin
                buffer_d = buffer_q >> DATA_WIDTH;
                cnt_d    = cnt_q - CW'(WB);
            end else begin
                buffer_d = '0;
                cnt_d    = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= STREAM;
            cnt_q    <= '0;
            buffer_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            buffer_q <= buffer_d;
        end
    end

endmodule

// File: tb/tb_trdb_align_stream.sv
// Bench for trdb_align_stream (DATA_WIDTH=32, PKT_LEN=64): byte-queue reference model feeding a word scoreboard.
// Expectations follow TRDB_ALIGN_LEN_HEADER_EN when it is defined for the build.
module tb_trdb_align_stream;

    localparam int DW = 32;
    localparam int PL = 64;
    localparam int WB = DW / 8;
    localparam int LW = $clog2(PL) + 1;
    localparam int BW = $clog2(WB) + 1;
`ifdef TRDB_ALIGN_LEN_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic [BW-1:0] nbytes;
    } word_t;

    typedef struct {
        int          len;
        logic [PL-1:0] bits;
        int          expP;
        logic [PL-1:0] expMasked;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstN;
    logic [PL-1:0] pktBits;
    logic [LW-1:0] pktLen;
    logic          pktValid;
    logic          pktReady;
    logic          flush;
    logic          flushDone;
    logic [DW-1:0] dataOut;
    logic [BW-1:0] dataBytes;
    logic          dataValid;
    logic          dataReady;

    int            checks = 0;
    int            passes = 0;
    logic [7:0]    pendQ[$];
    word_t         expQ[$];
    logic [7:0]    curP;
    logic [PL-1:0] curMasked;
    bit            randReady = 1'b0;
    vec_t          vecs[11];

    trdb_align_stream #(
        .DATA_WIDTH (DW),
        .PKT_LEN    (PL)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .pkt_bits_i   (pktBits),
        .pkt_len_i    (pktLen),
        .pkt_valid_i  (pktValid),
        .pkt_ready_o  (pktReady),
        .flush_i      (flush),
        .flush_done_o (flushDone),
        .data_o       (dataOut),
        .data_bytes_o (dataBytes),
        .data_valid_o (dataValid),
        .data_ready_i (dataReady)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic modelAccept(input logic [7:0] p, input logic [PL-1:0] masked);
        word_t w;
        if (HDR) begin
            pendQ.push_back(p);
        end
        for (int i = 0; i < int'(p); i++) begin
            pendQ.push_back(masked[i*8 +: 8]);
        end
        while (pendQ.size() >= WB) begin
            w.nbytes = BW'(WB);
            for (int i = 0; i < WB; i++) begin
                w.data[i*8 +: 8] = pendQ.pop_front();
            end
            expQ.push_back(w);
        end
    endtask

    task automatic modelFlush();
        word_t w;
        w.data   = '0;
        w.nbytes = BW'(pendQ.size());
        for (int i = 0; i < pendQ.size(); i++) begin
            w.data[i*8 +: 8] = pendQ[i];
        end
        if (pendQ.size() > 0) begin
            expQ.push_back(w);
        end
        pendQ.delete();
    endtask

    // Scoreboard: feed the model on every accepted packet and flush, compare every emitted word.
    always @(negedge clk) begin
        if (rstN) begin
            if (pktValid && pktReady) begin
                modelAccept(curP, curMasked);
            end
            if (flush) begin
                modelFlush();
            end
            if (dataValid && dataReady) begin
                if (expQ.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpectedWord: got bytes=%0d data=0x%0h, expected no word", dataBytes, dataOut);
                end else begin
                    word_t w;
                    w = expQ.pop_front();
                    checkOutput("word", {dataBytes, dataOut}, {w.nbytes, w.data});
                end
            end
        end
    end

    task automatic applyStimulus(input int len, input logic [PL-1:0] bits, input int p, input logic [PL-1:0] masked);
        bit done = 1'b0;
        pktLen    = LW'(len);
        pktBits   = bits;
        curP      = 8'(p);
        curMasked = masked;
        pktValid  = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (pktReady) begin
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (randReady) begin
                dataReady = 1'($urandom_range(0, 1));
            end
        end
        pktValid = 1'b0;
        if (!done) begin
            checks++;
            $display("[TB] FAIL acceptTimeout: got no pkt_ready_o in 100 cycles, expected acceptance");
        end
    endtask

    task automatic pulseFlush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic waitFlushDone();
        bit seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (flushDone) begin
                seen = 1'b1;
            end
        end
        checkOutput("flushDoneSeen", 64'(seen), 64'd1);
        if (seen) begin
            @(negedge clk);
            checkOutput("flushDonePulse", 64'(flushDone), 64'd0);
            checkOutput("readyAfterFlush", 64'(pktReady), 64'd1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bad;
        vecs[0]  = '{24,  64'hCCBBAA,              3, 64'hCCBBAA};
        vecs[1]  = '{12,  64'hFABC,                2, 64'h0ABC};
        vecs[2]  = '{8,   64'h55,                  1, 64'h55};
        vecs[3]  = '{0,   64'hFFFF,                0, 64'h0};
        vecs[4]  = '{64,  64'h0123456789ABCDEF,    8, 64'h0123456789ABCDEF};
        vecs[5]  = '{100, 64'hDEADBEEFCAFEF00D,    8, 64'hDEADBEEFCAFEF00D};
        vecs[6]  = '{1,   64'hFF,                  1, 64'h01};
        vecs[7]  = '{63,  64'hFFFFFFFFFFFFFFFF,    8, 64'h7FFFFFFFFFFFFFFF};
        vecs[8]  = '{17,  64'hFFFFFF,              3, 64'h1FFFF};
        vecs[9]  = '{40,  64'hFF1122334455,        5, 64'h1122334455};
        vecs[10] = '{7,   64'hAB,                  1, 64'h2B};

        rstN      = 1'b0;
        pktBits   = '0;
        pktLen    = '0;
        pktValid  = 1'b0;
        flush     = 1'b0;
        dataReady = 1'b1;
        curP      = '0;
        curMasked = '0;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstValid", 64'(dataValid), 64'd0);
        checkOutput("rstData", 64'(dataOut), 64'd0);
        checkOutput("rstBytes", 64'(dataBytes), 64'd0);
        checkOutput("rstFlushDone", 64'(flushDone), 64'd0);
        checkOutput("rstReady", 64'(pktReady), 64'd1);

        // One-cycle latency, then a five-cycle stall on the pending word.
        dataReady = 1'b0;
        applyStimulus(24, 64'hCCBBAA, 3, 64'hCCBBAA);
`ifdef TRDB_ALIGN_LEN_HEADER_EN
        checkOutput("latValid", 64'(dataValid), 64'd1);
        checkOutput("latData", 64'(dataOut), 64'hCCBBAA03);
        checkOutput("latBytes", 64'(dataBytes), 64'd4);
`else
        checkOutput("latValid", 64'(dataValid), 64'd0);
        checkOutput("latReady", 64'(pktReady), 64'd1);
        applyStimulus(8, 64'hDD, 1, 64'hDD);
        checkOutput("packValid", 64'(dataValid), 64'd1);
        checkOutput("packData", 64'(dataOut), 64'hDDCCBBAA);
`endif
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
`ifdef TRDB_ALIGN_LEN_HEADER_EN
            checkOutput("stallData", 64'(dataOut), 64'hCCBBAA03);
`else
            checkOutput("stallData", 64'(dataOut), 64'hDDCCBBAA);
`endif
            checkOutput("stallValid", 64'(dataValid), 64'd1);
            checkOutput("stallReady", 64'(pktReady), 64'd0);
        end
        @(posedge clk);
        #1;
        dataReady = 1'b1;
        @(posedge clk);
        #1;

        // Two short packets share one word, then a flush drains the leftover byte(s).
        dataReady = 1'b0;
        applyStimulus(12, 64'hFABC, 2, 64'h0ABC);
        applyStimulus(8, 64'h55, 1, 64'h55);
`ifdef TRDB_ALIGN_LEN_HEADER_EN
        checkOutput("mixValid", 64'(dataValid), 64'd1);
        checkOutput("mixData", 64'(dataOut), 64'h010ABC02);
`else
        checkOutput("mixValid", 64'(dataValid), 64'd0);
`endif
        dataReady = 1'b1;
        pulseFlush();
        waitFlushDone();

        // Reset while a three-byte partial word is pending in the flush.
        dataReady = 1'b0;
`ifdef TRDB_ALIGN_LEN_HEADER_EN
        applyStimulus(16, 64'h2211, 2, 64'h2211);
`else
        applyStimulus(24, 64'h332211, 3, 64'h332211);
`endif
        pulseFlush();
        repeat (2) @(negedge clk);
        checkOutput("partValid", 64'(dataValid), 64'd1);
        checkOutput("partBytes", 64'(dataBytes), 64'd3);
`ifdef TRDB_ALIGN_LEN_HEADER_EN
        checkOutput("partData", 64'(dataOut), 64'h221102);
`else
        checkOutput("partData", 64'(dataOut), 64'h332211);
`endif
        rstN = 1'b0;
        expQ.delete();
        pendQ.delete();
        #1;
        checkOutput("midRstValid", 64'(dataValid), 64'd0);
        checkOutput("midRstData", 64'(dataOut), 64'd0);
        checkOutput("midRstBytes", 64'(dataBytes), 64'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        dataReady = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (dataValid || flushDone) begin
                bad++;
            end
        end
        checkOutput("postRstQuiet", 64'(bad), 64'd0);
        checkOutput("postRstReady", 64'(pktReady), 64'd1);
        @(posedge clk);
        #1;

        // Table of packets under random backpressure; the scoreboard checks every word.
        randReady = 1'b1;
        for (int v = 0; v < 11; v++) begin
            applyStimulus(vecs[v].len, vecs[v].bits, vecs[v].expP, vecs[v].expMasked);
        end
        randReady = 1'b0;
        dataReady = 1'b1;
        pulseFlush();
        waitFlushDone();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
